reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file: successor to the single-write/dual-read integer register file used in the core's datapath.
- Adds configurable read-port count and a second write port for a dual-writeback pipeline.
- Adds optional same-cycle write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard for hazard detection by the issue stage.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary.
- BYPASS, 1, 1: a read of a register being written this cycle returns the new data; 0: returns the stored (old) value.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- we_a  in  1  write enable, port A.
- wa_a  in  ADDR_W  write address, port A.
- wd_a  in  DATA_W  write data, port A.
- we_b  in  1  write enable, port B.
- wa_b  in  ADDR_W  write address, port B.
- wd_b  in  DATA_W  write data, port B.
- ra  in  NUM_RD*ADDR_W  read addresses, flattened; port i = ra[i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  read data, flattened; port i = rd[i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  per-port busy flag for the addressed register.
- issue_en  in  1  mark destination register pending.
- issue_addr  in  ADDR_W  register to mark pending.
- busy_vec  out  2**ADDR_W  registered scoreboard bits.

Behaviour:
- Reset (rst_n low, asynchronous): all registers cleared to 0 and all busy bits cleared. While rst_n is low, rd = 0, rd_busy = 0 and busy_vec = 0. On deassertion, first write is accepted on the next rising edge.
- Writes: synchronous on rising clk when we_x = 1; one-cycle latency to storage.
- Write conflict: we_a and we_b both 1 with wa_a == wa_b: port B data is stored.
- ZERO_REG = 1:
  - Writes to address 0 are dropped and do not clear busy bit 0.
  - Reads of address 0 return 0.
  - issue_en to address 0 is ignored; busy bit 0 is constant 0.
- Reads: combinational, zero latency; all NUM_RD ports are independent and may target the same address.
- BYPASS = 1: if read address matches an enabled write address this cycle, rd = that write's data (port B priority on double match). The zero register overrides bypass.
- BYPASS = 0: rd shows the stored value; new data is visible the cycle after the write edge.
- Scoreboard, per register r, updated on rising clk:
  - set when issue_en and issue_addr == r;
  - cleared when either write port writes r;
  - set and clear in the same cycle on r: set wins (a newer producer is pending).
- Scoreboard outputs:
  - busy_vec is the registered scoreboard state.
  - rd_busy[i] = busy_vec[ra_i], with one exception: when BYPASS = 1 and a same-cycle write targets ra_i, rd_busy[i] = 0, because the data is available via bypass.
- Address width: there is no out-of-range condition; all 2**ADDR_W addresses are valid.
- Reset mid-operation: in-flight writes and issues in the cycle reset asserts are discarded.

Test Plan:
- Reset, then write port A to R1..R6 with 0xAAAA1111, 0xBBBB2222, 0xCCCC3333, 0x11113333, 0x22446688, 0x12345678 -> read pairs (R1,R2), (R3,R4), (R5,R6) on two ports return exactly those values; R0 reads 0.
- ZERO_REG = 1: write 0xDEADBEEF to R0 -> rd = 0 on all ports; busy_vec[0] stays 0 after issue_en to address 0.
- Same-cycle write R7 = 0x5A5A5A5A with ra0 = 7 -> BYPASS = 1: rd0 = 0x5A5A5A5A in the same cycle; BYPASS = 0: rd0 = 0 that cycle, 0x5A5A5A5A the next cycle.
- we_a and we_b both target R9, wd_a = 0x1, wd_b = 0x2 -> R9 reads 0x2 afterwards.
- issue_en to R3, then 2 idle cycles -> busy_vec[3] = 1 and rd_busy = 1 for a port reading R3. Write R3 -> busy clears the next cycle. Issue and write R3 in the same cycle -> busy_vec[3] stays 1.
- Assert rst_n low mid-stream after R1..R6 are written with busy bits set -> rd, rd_busy and busy_vec go to 0 immediately without a clock edge; all registers read 0 after release.

Source files
------------

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with dual write, optional bypass/zero register and busy scoreboard
// Storage and scoreboard reset asynchronously; reads, bypass and busy lookup are combinational.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_a,
  input  logic [ADDR_W-1:0]          wa_a,
  input  logic [DATA_W-1:0]          wd_a,
  input  logic                       we_b,
  input  logic [ADDR_W-1:0]          wa_b,
  input  logic [DATA_W-1:0]          wd_b,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Effective enables: writes and issues to the hardwired zero register vanish here.
  logic wen_a;
  logic wen_b;
  logic iss_en;
  logic [DEPTH-1:0] wsel_a;
  logic [DEPTH-1:0] wsel_b;
  logic [DEPTH-1:0] isel;

  assign wen_a  = we_a && !(HAS_ZERO && (wa_a == '0));
  assign wen_b  = we_b && !(HAS_ZERO && (wa_b == '0));
  assign iss_en = issue_en && !(HAS_ZERO && (issue_addr == '0));

  always_comb begin
    wsel_a = '0;
    wsel_b = '0;
    isel   = '0;
    if (wen_a)  wsel_a[wa_a]       = 1'b1;
    if (wen_b)  wsel_b[wa_b]       = 1'b1;
    if (iss_en) isel[issue_addr]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      if (wen_a) regs_q[wa_a] <= wd_a;
      // Port B is applied last so it wins a same-address collision.
      if (wen_b) regs_q[wa_b] <= wd_b;
    end
  end

  // A fresh issue marks a newer producer, so it overrides a completing write.
  always_comb begin
    busy_d = (busy_q & ~(wsel_a | wsel_b)) | isel;
    if (HAS_ZERO) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rbusy;

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    raddr   = '0;
    rdata   = '0;
    rbusy   = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      raddr = ra[i*ADDR_W +: ADDR_W];
      rdata = regs_q[raddr];
      rbusy = busy_q[raddr];
      if (HAS_BYP) begin
        if (wen_a && (wa_a == raddr)) begin
          rdata = wd_a;
          rbusy = 1'b0;
        end
        if (wen_b && (wa_b == raddr)) begin
          rdata = wd_b;
          rbusy = 1'b0;
        end
      end
      if (HAS_ZERO && (raddr == '0)) begin
        rdata = '0;
        rbusy = 1'b0;
      end
      // Bypass would otherwise leak write data while reset is held.
      if (!rst_n) begin
        rdata = '0;
        rbusy = 1'b0;
      end
      rd[i*DATA_W +: DATA_W] = rdata;
      rd_busy[i]             = rbusy;
    end
  end

endmodule
